// File: rtl/rotary_pkg.sv
// Shared FSM state encodings and default sizing for the rotary encoder array.
package rotary_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] A_FIRST = 2'd1;
  localparam logic [1:0] B_FIRST = 2'd2;
  localparam logic [1:0] WAIT    = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 1024;
  localparam int DEF_CNT_W           = 8;
endpackage

// File: rtl/input_debouncer.sv
// 2-FF synchroniser plus stability counter for one active-low raw pin; idle/reset value is 1.
// Latency: a clean raw edge reaches clean DEBOUNCE_CYCLES+2 cycles later; no backpressure.
module input_debouncer
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Any cycle of agreement restarts the stability window, so bounce never accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      clean <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == clean) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        clean <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end
endmodule

// File: rtl/rotary_encoder_array.sv
// Quadrature decoder array: debounced A/B/switch per channel -> up/down/press pulses; ROTARY_POSITION_EN adds position counters.
// Latency: raw edge to pulse is DEBOUNCE_CYCLES+3 cycles; no backpressure (pulses are fire-and-forget).
module rotary_encoder_array
  import rotary_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_a,
  input  logic [CHANNELS-1:0]       in_b,
  input  logic [CHANNELS-1:0]       switch,
  output logic [CHANNELS-1:0]       up,
  output logic [CHANNELS-1:0]       down,
  output logic [CHANNELS-1:0]       button,
  output logic [CHANNELS-1:0]       press,
  output logic [CHANNELS*CNT_W-1:0] position
);
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic       da, db, ds;
    logic [1:0] st, st_nxt;
    logic       up_nxt, dn_nxt;
    logic       up_q, dn_q, press_q, sw_q;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_da (
      .clk(clk), .rst_n(rst_n), .raw(in_a[ch]), .clean(da));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst_n(rst_n), .raw(in_b[ch]), .clean(db));
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ds (
      .clk(clk), .rst_n(rst_n), .raw(switch[ch]), .clean(ds));

    // Inputs are active-low: 0 means the contact has closed.
    always_comb begin
      st_nxt = st;
      up_nxt = 1'b0;
      dn_nxt = 1'b0;
      case (st)
        IDLE: begin
          if (!da && !db)  st_nxt = WAIT;
          else if (!da)    st_nxt = A_FIRST;
          else if (!db)    st_nxt = B_FIRST;
        end
        A_FIRST: begin
          if (!db) begin
            up_nxt = 1'b1;
            st_nxt = WAIT;
          end else if (da) begin
            st_nxt = IDLE;
          end
        end
        B_FIRST: begin
          if (!da) begin
            dn_nxt = 1'b1;
            st_nxt = WAIT;
          end else if (db) begin
            st_nxt = IDLE;
          end
        end
        WAIT: begin
          if (da && db) st_nxt = IDLE;
        end
        default: st_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st      <= IDLE;
        up_q    <= 1'b0;
        dn_q    <= 1'b0;
        sw_q    <= 1'b1;
        press_q <= 1'b0;
      end else begin
        st      <= st_nxt;
        up_q    <= up_nxt;
        dn_q    <= dn_nxt;
        sw_q    <= ds;
        press_q <= sw_q & ~ds;
      end
    end

    assign up[ch]     = up_q;
    assign down[ch]   = dn_q;
    assign button[ch] = ~ds;
    assign press[ch]  = press_q;

`ifdef ROTARY_POSITION_EN
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [CNT_W-1:0] pos_q;

    // Updates on the same edge the pulse rises, so position is current while up/down is high.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pos_q <= '0;
      else if (up_nxt) pos_q <= pos_q + ONE;
      else if (dn_nxt) pos_q <= pos_q - ONE;
    end

    assign position[ch*CNT_W +: CNT_W] = pos_q;
`else
    assign position[ch*CNT_W +: CNT_W] = '0;
`endif
  end
endmodule

// File: tb/tb_rotary_encoder_array.sv
// Scoreboard bench for rotary_encoder_array with CHANNELS=2, DEBOUNCE_CYCLES=4, CNT_W=4.
module tb_rotary_encoder_array;
  localparam int CH = 2;
  localparam int DB = 4;
  localparam int W  = 4;
`ifdef ROTARY_POSITION_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] in_a, in_b, switch;
  logic [CH-1:0] up, down, button, press;
  logic [CH*W-1:0] position;

  always #5 clk = ~clk;

  rotary_encoder_array #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .switch(switch),
    .up(up), .down(down), .button(button), .press(press), .position(position));

  typedef struct {
    int         ch;
    int         kind;   // 0 up, 1 down, 2 press
    logic [3:0] pos;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pulse_cnt = 0;
  logic [3:0] model_pos [CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_evt(input int ch, input int kind);
    exp_t e;
    if (POS_EN && kind == 0) model_pos[ch] = model_pos[ch] + 4'd1;
    if (POS_EN && kind == 1) model_pos[ch] = model_pos[ch] - 4'd1;
    e.ch   = ch;
    e.kind = kind;
    e.pos  = model_pos[ch];
    exp_q.push_back(e);
  endtask

  task automatic match(input int ch, input int kind);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].ch == ch && exp_q[i].kind == kind) idx = i;
    chk($sformatf("evt_expected ch%0d kind%0d", ch, kind), 32'(idx >= 0), 32'd1);
    if (idx >= 0) begin
      chk($sformatf("evt_pos ch%0d", ch), 32'(position[ch*W +: W]), 32'(exp_q[idx].pos));
      exp_q.delete(idx);
    end
    pulse_cnt++;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int c = 0; c < CH; c++) begin
        if (up[c] || down[c] || press[c]) begin
          chk($sformatf("up_down_excl ch%0d", c), 32'(up[c] & down[c]), 32'd0);
          if (up[c])    match(c, 0);
          if (down[c])  match(c, 1);
          if (press[c]) match(c, 2);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    in_a   = '1;
    in_b   = '1;
    switch = '1;
    tick(2);
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++) model_pos[c] = 4'd0;
    exp_q.delete();
    tick(2);
  endtask

  task automatic cw(input int ch);
    in_a[ch] = 1'b0;
    tick(10);
    expect_evt(ch, 0);
    in_b[ch] = 1'b0;
    tick(10);
    in_a[ch] = 1'b1;
    in_b[ch] = 1'b1;
    tick(12);
  endtask

  task automatic ccw(input int ch);
    in_b[ch] = 1'b0;
    tick(10);
    expect_evt(ch, 1);
    in_a[ch] = 1'b0;
    tick(10);
    in_a[ch] = 1'b1;
    in_b[ch] = 1'b1;
    tick(12);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    in_a = '1; in_b = '1; switch = '1; rst_n = 1'b0;
    for (int c = 0; c < CH; c++) model_pos[c] = 4'd0;
    tick(3);
    chk("rst_up",       32'(up),       32'd0);
    chk("rst_down",     32'(down),     32'd0);
    chk("rst_press",    32'(press),    32'd0);
    chk("rst_button",   32'(button),   32'd0);
    chk("rst_position", 32'(position), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Clockwise detent on ch0 with pulse latency measured from B falling
    in_a[0] = 1'b0;
    tick(10);
    expect_evt(0, 0);
    in_b[0] = 1'b0;
    n = 0;
    while (!up[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("up_latency", n, DB + 3);
    tick(10);
    in_a[0] = 1'b1;
    in_b[0] = 1'b1;
    tick(12);
    chk("cw_pos0", 32'(position[3:0]), POS_EN ? 32'h1 : 32'h0);
    chk("cw_queue", exp_q.size(), 0);

    // Counter-clockwise on ch1; ch0 must be untouched
    ccw(1);
    chk("ccw_pos1", 32'(position[7:4]), POS_EN ? 32'hF : 32'h0);
    chk("ccw_pos0", 32'(position[3:0]), 32'(model_pos[0]));

    // Bounce: 2-cycle toggles, then a 3-cycle glitch, never reach the debounced value
    base = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      in_a[0] = ~in_a[0];
      tick(2);
      chk("bounce_da", 32'(dut.g_ch[0].da), 32'd1);
    end
    tick(10);
    in_a[0] = 1'b0;
    tick(3);
    in_a[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_da", 32'(dut.g_ch[0].da), 32'd1);
    end
    chk("bounce_pulses", pulse_cnt - base, 0);

    // Abort: A alone falls and recovers
    in_a[0] = 1'b0;
    tick(10);
    chk("abort_afirst", 32'(dut.g_ch[0].st), 32'd1);
    in_a[0] = 1'b1;
    tick(12);
    chk("abort_idle", 32'(dut.g_ch[0].st), 32'd0);
    // Simultaneous fall goes straight to WAIT with no pulse
    in_a[0] = 1'b0;
    in_b[0] = 1'b0;
    tick(12);
    chk("simul_wait", 32'(dut.g_ch[0].st), 32'd3);
    in_a[0] = 1'b1;
    in_b[0] = 1'b1;
    tick(12);
    chk("simul_idle", 32'(dut.g_ch[0].st), 32'd0);
    chk("abort_pulses", pulse_cnt - base, 0);

    // Button: debounced level after DB+2, one press pulse, silent release
    base = pulse_cnt;
    expect_evt(0, 2);
    switch[0] = 1'b0;
    n = 0;
    while (!button[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("btn_latency", n, DB + 2);
    tick(4);
    chk("btn_held", 32'(button[0]), 32'd1);
    switch[0] = 1'b1;
    tick(10);
    chk("btn_release", 32'(button[0]), 32'd0);
    chk("btn_pulses", pulse_cnt - base, 1);

    // Wrap at 4 bits
    do_reset();
    for (int i = 0; i < 8; i++) cw(0);
    chk("wrap8", 32'(position[3:0]), POS_EN ? 32'h8 : 32'h0);
    cw(0);
    chk("wrap9", 32'(position[3:0]), POS_EN ? 32'h9 : 32'h0);
    for (int i = 0; i < 8; i++) cw(0);
    chk("wrap17", 32'(position[3:0]), POS_EN ? 32'h1 : 32'h0);
    chk("wrap_queue", exp_q.size(), 0);

    // Asynchronous reset in A_FIRST with the up pulse about to fire
    in_a[0] = 1'b0;
    tick(10);
    chk("pre_rst_afirst", 32'(dut.g_ch[0].st), 32'd1);
    in_b[0] = 1'b0;
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_up",       32'(up),       32'd0);
    chk("async_down",     32'(down),     32'd0);
    chk("async_position", 32'(position), 32'd0);
    chk("async_state",    32'(dut.g_ch[0].st), 32'd0);
    in_a = '1;
    in_b = '1;
    tick(2);
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++) model_pos[c] = 4'd0;
    tick(5);
    in_b[0] = 1'b0;
    tick(10);
    chk("post_rst_bfirst", 32'(dut.g_ch[0].st), 32'd2);
    expect_evt(0, 1);
    in_a[0] = 1'b0;
    tick(10);
    in_a[0] = 1'b1;
    in_b[0] = 1'b1;
    tick(12);
    chk("post_rst_pos", 32'(position[3:0]), POS_EN ? 32'hF : 32'h0);
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
